mul_operand_seq: RTL and testbench

- Upstream operand sequencer for the repeated-addition multiplier core.
- Accepts an (a, b) operand pair over a valid/ready handshake and pulses start to the core.
- Serialises both operands onto the core's shared data bus, larger first. The smaller operand becomes the core's down-count, which minimises core latency.
- Waits for done, captures the product, clears the core, and presents the result downstream over valid/ready. Zero operands bypass the core; a stuck core is caught by a timeout.

---
 rtl/mul_operand_seq.sv | 149 ++++++++++++++
 tb/tb_mul_operand_seq.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_operand_seq.sv
// Operand sequencer in front of the repeated-addition multiplier core.
// Takes an (a, b) pair, feeds the larger operand then the smaller one over
// the core's shared bus, waits for done (or gives up after TIMEOUT cycles),
// clears the core and hands the product downstream. Zero operands skip the
// core entirely.
module mul_operand_seq #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 70000,
    parameter int TW      = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             mul_start,
    output logic [WIDTH-1:0] mul_data,
    input  logic             mul_done,
    input  logic [WIDTH-1:0] mul_product,
    output logic             mul_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_product,
    output logic             out_err,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_LOAD_A,
        S_LOAD_B,
        S_WAIT,
        S_CLEAR,
        S_OUT
    } state_t;

    state_t           state_q, state_d;
    logic             armed_q;
    logic [WIDTH-1:0] big_q, big_d;
    logic [WIDTH-1:0] small_q, small_d;
    logic [WIDTH-1:0] prod_q, prod_d;
    logic             err_q, err_d;
    logic [TW-1:0]    cnt_q, cnt_d;
    logic             accept;

    localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

    // armed_q keeps in_ready low while rst is held, even though state is IDLE
    assign accept = in_valid && in_ready;

    // Next-state logic and operand/result register updates
    always_comb begin
        state_d = state_q;
        big_d   = big_q;
        small_d = small_q;
        prod_d  = prod_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    // Larger operand is loaded as A; the smaller one becomes
                    // the core's down-count so the core finishes sooner.
                    if (in_a >= in_b) begin
                        big_d   = in_a;
                        small_d = in_b;
                    end else begin
                        big_d   = in_b;
                        small_d = in_a;
                    end
                    if ((in_a == '0) || (in_b == '0)) begin
                        prod_d  = '0;
                        err_d   = 1'b0;
                        state_d = S_OUT;
                    end else begin
                        state_d = S_START;
                    end
                end
            end
            S_START:  state_d = S_LOAD_A;
            S_LOAD_A: state_d = S_LOAD_B;
            S_LOAD_B: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + TW'(1);
                // done wins over a timeout landing on the same edge
                if (mul_done) begin
                    prod_d  = mul_product;
                    err_d   = 1'b0;
                    state_d = S_CLEAR;
                end else if (cnt_q == CNT_LAST) begin
                    prod_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR:  state_d = S_OUT;
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default:  state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts straight to IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            armed_q <= 1'b0;
            big_q   <= '0;
            small_q <= '0;
            prod_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            armed_q <= 1'b1;
            big_q   <= big_d;
            small_q <= small_d;
            prod_q  <= prod_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decoded from the state register and held registers only
    always_comb begin
        in_ready    = armed_q && (state_q == S_IDLE);
        mul_start   = (state_q == S_START);
        mul_clr     = (state_q == S_CLEAR);
        out_valid   = (state_q == S_OUT);
        busy        = (state_q != S_IDLE);
        out_product = prod_q;
        out_err     = err_q;
        mul_data    = '0;
        if (state_q == S_LOAD_A) begin
            mul_data = big_q;
        end else if (state_q == S_LOAD_B) begin
            mul_data = small_q;
        end
    end

endmodule

// File: tb/tb_mul_operand_seq.sv
// Bench for mul_operand_seq: behavioural multiplier core, transaction-level
// timeline model checked every cycle, directed cases with literal results
// and a randomized run.
module tb_mul_operand_seq;

    localparam int W  = 16;
    localparam int TO = 20;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         mul_start;
    logic [W-1:0] mul_data;
    logic         mul_done;
    logic [W-1:0] mul_product;
    logic         mul_clr;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_product;
    logic         out_err;
    logic         busy;

    int n_cmp  = 0;
    int n_fail = 0;
    int core_delay = 0;

    mul_operand_seq #(.WIDTH(W), .TIMEOUT(TO), .TW(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .mul_start  (mul_start),
        .mul_data   (mul_data),
        .mul_done   (mul_done),
        .mul_product(mul_product),
        .mul_clr    (mul_clr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_product(out_product),
        .out_err    (out_err),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [31:0] f;
        f = {16'd0, a} * {16'd0, b};
        return f[W-1:0];
    endfunction

    // Behavioural core: sees start, latches A then B, raises done after
    // core_delay WAIT cycles (0 = never), holds it until mul_clr.
    int           c_phase = 0;
    int           c_wcnt  = 0;
    logic [W-1:0] c_a = '0;
    logic [W-1:0] c_b = '0;

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            c_phase     <= 0;
            c_wcnt      <= 0;
            mul_done    <= 1'b0;
            mul_product <= '0;
        end else if (mul_clr) begin
            c_phase  <= 0;
            mul_done <= 1'b0;
        end else begin
            case (c_phase)
                0: if (mul_start) c_phase <= 1;
                1: begin c_a <= mul_data; c_phase <= 2; end
                2: begin c_b <= mul_data; c_phase <= 3; c_wcnt <= 0; end
                default: begin
                    c_wcnt <= c_wcnt + 1;
                    if (c_wcnt + 1 == core_delay) begin
                        mul_done    <= 1'b1;
                        mul_product <= c_a * c_b;
                    end
                end
            endcase
        end
    end

    // Transaction-level model: k counts cycles since the accept edge.
    logic         m_active = 1'b0;
    logic         m_armed  = 1'b0;
    logic         m_bypass = 1'b0;
    int           m_k      = 0;
    int           m_outk   = 0;
    logic [W-1:0] m_big    = '0;
    logic [W-1:0] m_small  = '0;
    logic [W-1:0] m_prod   = '0;
    logic         m_err    = 1'b0;
    logic         in_zero;
    logic         delay_ok;

    assign in_zero  = (in_a == '0) || (in_b == '0);
    assign delay_ok = (core_delay >= 1) && (core_delay <= TO);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active <= 1'b0;
            m_armed  <= 1'b0;
        end else begin
            m_armed <= 1'b1;
            if (m_active) begin
                if (m_k == m_outk) begin
                    if (out_ready) m_active <= 1'b0;
                end else begin
                    m_k <= m_k + 1;
                end
            end else if (m_armed && in_valid) begin
                m_active <= 1'b1;
                m_k      <= 1;
                m_bypass <= in_zero;
                m_big    <= (in_a >= in_b) ? in_a : in_b;
                m_small  <= (in_a >= in_b) ? in_b : in_a;
                if (in_zero) begin
                    m_outk <= 1;
                    m_prod <= '0;
                    m_err  <= 1'b0;
                end else if (delay_ok) begin
                    m_outk <= core_delay + 5;
                    m_prod <= ref_prod(in_a, in_b);
                    m_err  <= 1'b0;
                end else begin
                    m_outk <= TO + 5;
                    m_prod <= '0;
                    m_err  <= 1'b1;
                end
            end
        end
    end

    logic         e_ready, e_busy, e_ov, e_start, e_clr;
    logic [W-1:0] e_data;
    logic         e_core;

    assign e_core  = m_active && !m_bypass;
    assign e_ready = m_armed && !m_active && !rst;
    assign e_busy  = m_active;
    assign e_ov    = m_active && (m_k == m_outk);
    assign e_start = e_core && (m_k == 1);
    assign e_clr   = e_core && (m_k == m_outk - 1);
    assign e_data  = (e_core && m_k == 2) ? m_big : ((e_core && m_k == 3) ? m_small : '0);

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        chk("in_ready",  32'(in_ready),  32'(e_ready));
        chk("busy",      32'(busy),      32'(e_busy));
        chk("out_valid", 32'(out_valid), 32'(e_ov));
        chk("mul_start", 32'(mul_start), 32'(e_start));
        chk("mul_clr",   32'(mul_clr),   32'(e_clr));
        chk("mul_data",  32'(mul_data),  32'(e_data));
        if (e_ov) begin
            chk("out_product", 32'(out_product), 32'(m_prod));
            chk("out_err",     32'(out_err),     32'(m_err));
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready_wait", 32'(in_ready), 32'd1);
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int d,
                         input int hold, output int lat, output logic [W-1:0] prod,
                         output logic err, output int starts, output int clrs,
                         output logic [W-1:0] da, output logic [W-1:0] db);
        lat = 0; starts = 0; clrs = 0; da = '0; db = '0;
        wait_ready();
        #1;
        in_a = a; in_b = b; core_delay = d; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (mul_start) starts++;
            if (mul_clr) clrs++;
            if (lat == 2) da = mul_data;
            if (lat == 3) db = mul_data;
        end while (!out_valid && lat < 200);
        if (!out_valid) chk("out_valid_wait", 32'(out_valid), 32'd1);
        prod = out_product;
        err  = out_err;
        for (int i = 0; i < hold; i++) begin
            #1;
            in_valid = 1'b1; in_a = 16'd11; in_b = 16'd13;
            @(negedge clk);
        end
        #1;
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int           lat, starts, clrs;
        logic [W-1:0] prod, da, db;
        logic         err;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready",    32'(in_ready),    32'd0);
        chk("rst_busy",        32'(busy),        32'd0);
        chk("rst_mul_start",   32'(mul_start),   32'd0);
        chk("rst_mul_data",    32'(mul_data),    32'd0);
        chk("rst_mul_clr",     32'(mul_clr),     32'd0);
        chk("rst_out_valid",   32'(out_valid),   32'd0);
        chk("rst_out_product", 32'(out_product), 32'd0);
        chk("rst_out_err",     32'(out_err),     32'd0);
        #1 rst = 1'b0;

        do_op(16'd7, 16'd3, 3, 0, lat, prod, err, starts, clrs, da, db);
        chk("7x3_lat",  32'(lat),  32'd8);
        chk("7x3_a",    32'(da),   32'd7);
        chk("7x3_b",    32'(db),   32'd3);
        chk("7x3_prod", 32'(prod), 32'd21);
        chk("7x3_err",  32'(err),  32'd0);
        chk("7x3_clr",  32'(clrs), 32'd1);

        do_op(16'd2, 16'd9, 2, 0, lat, prod, err, starts, clrs, da, db);
        chk("2x9_a",    32'(da),   32'd9);
        chk("2x9_b",    32'(db),   32'd2);
        chk("2x9_prod", 32'(prod), 32'd18);

        do_op(16'd0, 16'd500, 3, 0, lat, prod, err, starts, clrs, da, db);
        chk("0x500_start", 32'(starts), 32'd0);
        chk("0x500_lat",   32'(lat),    32'd1);
        chk("0x500_prod",  32'(prod),   32'd0);

        do_op(16'd65535, 16'd0, 3, 0, lat, prod, err, starts, clrs, da, db);
        chk("max_x0_start", 32'(starts), 32'd0);
        chk("max_x0_lat",   32'(lat),    32'd1);
        chk("max_x0_prod",  32'(prod),   32'd0);

        do_op(16'd300, 16'd300, 4, 5, lat, prod, err, starts, clrs, da, db);
        chk("300x300_prod", 32'(prod), 32'd24464);
        chk("300x300_hold", 32'(out_product), 32'd24464);

        do_op(16'd1234, 16'd5678, 0, 1, lat, prod, err, starts, clrs, da, db);
        chk("tmo_err",  32'(err),  32'd1);
        chk("tmo_prod", 32'(prod), 32'd0);
        chk("tmo_lat",  32'(lat),  32'(TO + 5));
        chk("tmo_clr",  32'(clrs), 32'd1);

        wait_ready();
        #1;
        in_a = 16'd6; in_b = 16'd7; core_delay = 0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (6) @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy",      32'(busy),        32'd0);
        chk("mid_rst_mul_clr",   32'(mul_clr),     32'd0);
        chk("mid_rst_out_valid", 32'(out_valid),   32'd0);
        chk("mid_rst_in_ready",  32'(in_ready),    32'd0);
        chk("mid_rst_out_prod",  32'(out_product), 32'd0);
        #1 rst = 1'b0;
        do_op(16'd5, 16'd4, 2, 0, lat, prod, err, starts, clrs, da, db);
        chk("5x4_prod", 32'(prod), 32'd20);
        chk("5x4_err",  32'(err),  32'd0);

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            ra = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
            rb = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 300));
            if ($urandom_range(0, 1) == 1) begin
                logic [W-1:0] t;
                t = ra; ra = rb; rb = t;
            end
            do_op(ra, rb, int'($urandom_range(0, TO + 4)), int'($urandom_range(0, 3)),
                  lat, prod, err, starts, clrs, da, db);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
